sisc_fetch: RTL and testbench

SISC_FETCH -- requirements
Module: sisc_fetch

---
 rtl/sisc_fetch.sv | 84 ++++++++
 tb/tb_sisc_fetch.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/sisc_fetch.sv
// sisc_fetch: instruction prefetch unit with a 2-entry queue, one outstanding request and branch flush
module sisc_fetch (
    input  logic        clk,
    input  logic        rst_f,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_data,
    input  logic        ir_load,
    input  logic        br_taken,
    input  logic [15:0] br_addr,
    output logic [31:0] ir,
    output logic [3:0]  opcode,
    output logic [3:0]  mm,
    output logic [15:0] pc_out,
    output logic        q_valid
);
    typedef enum logic [1:0] {IDLE, REQ, DRAIN} state_t;
    state_t      state, state_n;
    logic [1:0]  count, count_n, widx;
    logic [15:0] fpc;
    logic [47:0] q [2];
    logic        push, pop, issue;

    assign opcode  = ir[31:28];
    assign mm      = ir[27:24];
    assign q_valid = count != 2'd0;

    // Next state, queue push/pop and request issue; a branch kills any push and the queue contents
    always_comb begin
        state_n = state;
        push    = 1'b0;
        issue   = 1'b0;
        case (state)
            IDLE: begin
                issue   = !br_taken && count != 2'd2;
                state_n = issue ? REQ : IDLE;
            end
            REQ: begin
                push    = imem_ack && !br_taken;
                state_n = imem_ack ? IDLE : (br_taken ? DRAIN : REQ);
            end
            DRAIN:   state_n = imem_ack ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
        pop     = ir_load && !br_taken && count != 2'd0;
        count_n = br_taken ? 2'd0 : count + {1'b0, push} - {1'b0, pop};
        widx    = count - {1'b0, pop};
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst_f) state <= IDLE;
        else       state <= state_n;
    end

    // Request, fetch pointer, queue occupancy and instruction register
    always_ff @(posedge clk) begin
        if (rst_f) begin
            imem_req  <= 1'b0;
            imem_addr <= 16'h0000;
            fpc       <= 16'h0000;
            count     <= 2'd0;
            ir        <= 32'h0;
            pc_out    <= 16'h0000;
        end else begin
            imem_req <= state_n != IDLE;
            count    <= count_n;
            if (issue) imem_addr <= fpc;
            if (br_taken)  fpc <= br_addr;
            else if (push) fpc <= imem_addr + 16'd1;
            if (pop) begin
                ir     <= q[0][47:16];
                pc_out <= q[0][15:0];
            end
        end
    end

    // Queue storage: head shifts on pop, new entry lands behind the surviving entries
    always_ff @(posedge clk) begin
        if (pop)  q[0]       <= q[1];
        if (push) q[widx[0]] <= {imem_data, imem_addr};
    end
endmodule

// File: tb/tb_sisc_fetch.sv
// tb_sisc_fetch: directed checks of sisc_fetch prefetch, branch flush, wrap and reset behaviour
module tb_sisc_fetch;
    logic        clk = 1'b0;
    logic        rst_f = 1'b1;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        ir_load = 1'b0;
    logic        br_taken = 1'b0;
    logic [15:0] br_addr = 16'h0;
    logic [31:0] ir;
    logic [3:0]  opcode, mm;
    logic [15:0] pc_out;
    logic        q_valid;
    logic        ack_en = 1'b0;
    int          checks = 0;
    int          failures = 0;

    sisc_fetch dut (
        .clk(clk), .rst_f(rst_f), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .ir_load(ir_load),
        .br_taken(br_taken), .br_addr(br_addr), .ir(ir), .opcode(opcode),
        .mm(mm), .pc_out(pc_out), .q_valid(q_valid)
    );

    always #5 clk = ~clk;

    // Memory image: four programmed words, everything else tagged with its address
    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h1100_0005;
            16'h0001: return 32'h8800_0001;
            16'h0002: return 32'h2000_0003;
            16'h0003: return 32'hF000_0000;
            default:  return {16'hD000, a};
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive controls and the memory response, then settle just after the edge
    task automatic tick(input logic ld, input logic br, input logic [15:0] ba);
        ir_load   = ld;
        br_taken  = br;
        br_addr   = ba;
        imem_ack  = imem_req && ack_en;
        imem_data = mem_word(imem_addr);
        @(posedge clk);
        #1;
        ir_load  = 1'b0;
        br_taken = 1'b0;
        imem_ack = 1'b0;
    endtask

    initial begin
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("rst_req", imem_req, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_ir", ir, 0);
        check("rst_opcode", opcode, 0);
        check("rst_mm", mm, 0);
        check("rst_pc", pc_out, 0);
        check("rst_qv", q_valid, 0);
        rst_f  = 1'b0;
        ack_en = 1'b1;
        tick(0, 0, 0);
        check("first_req", imem_req, 1);
        check("first_addr", imem_addr, 16'h0000);
        tick(0, 0, 0);
        check("fill0_qv", q_valid, 1);
        check("fill0_req_drop", imem_req, 0);
        tick(0, 0, 0);
        check("req1_addr", imem_addr, 16'h0001);
        tick(0, 0, 0);
        check("fill1_qv", q_valid, 1);
        tick(0, 0, 0);
        check("full_no_req_a", imem_req, 0);
        tick(0, 0, 0);
        check("full_no_req_b", imem_req, 0);
        tick(1, 0, 0);
        check("ld0_ir", ir, 32'h1100_0005);
        check("ld0_opcode", opcode, 4'h1);
        check("ld0_mm", mm, 4'h1);
        check("ld0_pc", pc_out, 16'h0000);
        tick(0, 0, 0);
        check("req2_req", imem_req, 1);
        check("req2_addr", imem_addr, 16'h0002);
        tick(1, 0, 0);
        check("pushpop1_pc", pc_out, 16'h0001);
        check("pushpop1_ir", ir, 32'h8800_0001);
        check("pushpop1_qv", q_valid, 1);
        tick(0, 0, 0);
        check("req3_addr", imem_addr, 16'h0003);
        tick(1, 0, 0);
        check("pushpop2_pc", pc_out, 16'h0002);
        check("pushpop2_ir", ir, 32'h2000_0003);
        ack_en = 1'b0;
        tick(0, 0, 0);
        check("req4_addr", imem_addr, 16'h0004);
        tick(0, 0, 0);
        check("wait1_addr", imem_addr, 16'h0004);
        tick(0, 1, 16'h0040);
        check("br_hold_req", imem_req, 1);
        check("br_hold_addr", imem_addr, 16'h0004);
        check("br_flush_qv", q_valid, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0);
            check("drain_addr", imem_addr, 16'h0004);
            check("drain_req", imem_req, 1);
        end
        ack_en = 1'b1;
        tick(0, 0, 0);
        check("drop_req", imem_req, 0);
        check("drop_qv", q_valid, 0);
        tick(0, 0, 0);
        check("redirect_req", imem_req, 1);
        check("redirect_addr", imem_addr, 16'h0040);
        check("redirect_qv", q_valid, 0);
        tick(0, 0, 0);
        check("redirect_fill_qv", q_valid, 1);
        tick(0, 0, 0);
        check("req41_addr", imem_addr, 16'h0041);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("full2_req", imem_req, 0);
        tick(1, 1, 16'h0100);
        check("brld_ir", ir, 32'h2000_0003);
        check("brld_pc", pc_out, 16'h0002);
        check("brld_qv", q_valid, 0);
        tick(1, 0, 0);
        check("empty_ld_ir", ir, 32'h2000_0003);
        check("empty_ld_pc", pc_out, 16'h0002);
        check("br100_addr", imem_addr, 16'h0100);
        tick(0, 1, 16'hFFFF);
        check("ackbr_req", imem_req, 0);
        check("ackbr_qv", q_valid, 0);
        tick(0, 0, 0);
        check("wrap_addr0", imem_addr, 16'hFFFF);
        tick(0, 0, 0);
        check("wrap_fill0_qv", q_valid, 1);
        tick(0, 0, 0);
        check("wrap_addr1", imem_addr, 16'h0000);
        tick(0, 0, 0);
        tick(0, 0, 0);
        check("wrap_full_req", imem_req, 0);
        ack_en = 1'b0;
        tick(1, 0, 0);
        check("wrap_pop0_pc", pc_out, 16'hFFFF);
        check("wrap_pop0_ir", ir, 32'hD000_FFFF);
        tick(1, 0, 0);
        check("wrap_pop1_pc", pc_out, 16'h0000);
        check("wrap_pop1_ir", ir, 32'h1100_0005);
        check("wrap_next_addr", imem_addr, 16'h0001);
        tick(0, 0, 0);
        check("pend_req", imem_req, 1);
        rst_f  = 1'b1;
        ack_en = 1'b1;
        tick(0, 0, 0);
        check("mid_rst_req", imem_req, 0);
        check("mid_rst_addr", imem_addr, 0);
        check("mid_rst_ir", ir, 0);
        check("mid_rst_pc", pc_out, 0);
        check("mid_rst_qv", q_valid, 0);
        check("mid_rst_opcode", opcode, 0);
        rst_f = 1'b0;
        tick(0, 0, 0);
        check("post_rst_req", imem_req, 1);
        check("post_rst_addr", imem_addr, 16'h0000);
        tick(0, 0, 0);
        check("post_rst_qv", q_valid, 1);
        tick(1, 0, 0);
        check("post_rst_ir", ir, 32'h1100_0005);
        check("post_rst_pc", pc_out, 16'h0000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
